led_avg_multi: RTL

//  Multi-channel windowed magnitude averager feeding the LED level display.

---
 rtl/led_avg_pkg.sv | 24 ++
 rtl/led_avg_ch.sv | 74 +++++++
 rtl/led_avg_multi.sv | 80 ++++++++
 3 files changed

// File: rtl/led_avg_pkg.sv
// Shared types and helpers for the multi-channel LED magnitude averager.
// Optional peak-hold feature is selected with the LED_AVG_PEAK_HOLD_EN macro.
package led_avg_pkg;

  typedef enum logic {
    StIdle,
    StAccum
  } state_e;

  // Accumulator width that holds a full window of saturated magnitudes without overflow.
  function automatic int unsigned acc_width(input int unsigned smpl_w, input int unsigned win_log2);
    return smpl_w - 1 + win_log2;
  endfunction

  // |x| of a sign-extended w-bit sample; the most negative code saturates to 2**(w-1)-1.
  function automatic logic [31:0] mag_sat(input logic signed [31:0] x, input int unsigned w);
    logic [31:0] lim;
    logic [31:0] m;
    lim = (32'd1 << (w - 1)) - 32'd1;
    m   = (x < 32'sd0) ? 32'(-x) : 32'(x);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/led_avg_ch.sv
// One channel: magnitude accumulator, window-mean register and optional peak tracker.
// Peak tracking is built only when LED_AVG_PEAK_HOLD_EN is defined; otherwise pk is 0.
module led_avg_ch
  import led_avg_pkg::*;
#(
  parameter int unsigned SMPL_W   = 16,
  parameter int unsigned WIN_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     add,
  input  logic                     close,
  input  logic signed [SMPL_W-1:0] smpl,
  output logic        [SMPL_W-1:0] avg,
  output logic        [SMPL_W-1:0] pk
);

  localparam int unsigned ACC_W = acc_width(SMPL_W, WIN_LOG2);

  logic [31:0]       mag32;
  logic [SMPL_W-1:0] mag;
  logic [ACC_W-1:0]  accum;
  logic [ACC_W-1:0]  sum;
  logic              unused_mag;

  assign mag32      = mag_sat(32'(smpl), SMPL_W);
  assign mag        = mag32[SMPL_W-1:0];
  assign unused_mag = ^mag32;
  assign sum        = accum + ACC_W'(mag);

  // The closing sample is folded into the mean directly, so windows run back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      accum <= '0;
      avg   <= '0;
    end else if (clr) begin
      accum <= '0;
    end else if (add) begin
      if (close) begin
        avg   <= SMPL_W'(sum >> WIN_LOG2);
        accum <= '0;
      end else begin
        accum <= sum;
      end
    end
  end

`ifdef LED_AVG_PEAK_HOLD_EN
  logic [SMPL_W-1:0] peak;
  logic [SMPL_W-1:0] peak_nxt;

  assign peak_nxt = (mag > peak) ? mag : peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak <= '0;
      pk   <= '0;
    end else if (clr) begin
      peak <= '0;
    end else if (add) begin
      if (close) begin
        pk   <= peak_nxt;
        peak <= '0;
      end else begin
        peak <= peak_nxt;
      end
    end
  end
`else
  assign pk = '0;
`endif

endmodule

// File: rtl/led_avg_multi.sv
// Multi-channel windowed |sample| averager for the LED level display.
// Define LED_AVG_PEAK_HOLD_EN to also publish the per-window peak magnitude on pk_out.
module led_avg_multi
  import led_avg_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SMPL_W   = 16,
  parameter int unsigned WIN_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sequencing,
  input  logic                     smpl_vld,
  input  logic [NUM_CH*SMPL_W-1:0] smpl_in,
  output logic [NUM_CH*SMPL_W-1:0] avg_out,
  output logic                     avg_vld,
  output logic [NUM_CH*SMPL_W-1:0] pk_out
);

  localparam logic [WIN_LOG2-1:0] CNT_MAX = '1;

  state_e              state;
  logic [WIN_LOG2-1:0] cnt;
  logic                clr;
  logic                add;
  logic                close;

  // Dropping sequencing overrides everything else, including a closing sample.
  assign clr   = ~sequencing;
  assign add   = sequencing & smpl_vld;
  assign close = add && (state == StAccum) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      case (state)
        StIdle: begin
          if (sequencing) begin
            state <= StAccum;
            if (smpl_vld) cnt <= cnt + 1'b1;
          end
        end
        StAccum: begin
          if (!sequencing) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (smpl_vld) begin
            cnt     <= cnt + 1'b1;
            avg_vld <= (cnt == CNT_MAX);
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    led_avg_ch #(
      .SMPL_W  (SMPL_W),
      .WIN_LOG2(WIN_LOG2)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .add  (add),
      .close(close),
      .smpl (smpl_in[c*SMPL_W +: SMPL_W]),
      .avg  (avg_out[c*SMPL_W +: SMPL_W]),
      .pk   (pk_out[c*SMPL_W +: SMPL_W])
    );
  end

endmodule
